// File: rtl/ss_dp_pkg.sv
// ss_dp_pkg: shared definitions for the ADMA data-path stage.
// Holds the dp state encodings, err bit indices, default sizing and the
// handshake bundle that ss_dp registers towards both scatter-gather engines.
package ss_dp_pkg;

    localparam int unsigned DP_AW    = 4;   // log2 FIFO depth
    localparam int unsigned DP_BURST = 4;   // entries needed to start a burst
    localparam int unsigned DP_SKID  = 2;   // margin at which stop is raised
    localparam int unsigned DATA_W   = 64;

    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UNF = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } dp_state_e;

    // Flow-control handshakes to the source and destination engines
    typedef struct packed {
        logic src_start;
        logic src_stop;
        logic src_end;
        logic dst_start;
        logic dst_stop;
        logic dst_end;
    } dp_hs_t;

endpackage

// File: rtl/ss_fifo64.sv
// ss_fifo64: synchronous 2^AW x 64 FIFO, registered write, asynchronous read.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; push/pop/din
// requests (push ignored when full, pop ignored when empty); clr synchronous
// flush; dout head entry; level registered occupancy; full/empty flags.
module ss_fifo64
    import ss_dp_pkg::*;
#(
    parameter int unsigned AW = DP_AW
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]     wr_ptr_q, rd_ptr_q, level_q;
    logic [LW-1:0]     wr_ptr_d, rd_ptr_d, level_d;
    logic              do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    // Pointer / occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + LW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + LW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ss_dp.sv
// ss_dp: data-path stage between the source (read) and destination (write)
// scatter-gather engines of one ADMA channel.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; ss_go/ss_done
// job start and abort from ss_adma; rd_dat/src_xfer/src_last source beats;
// dst_xfer/dst_last destination beats; wr_dat FIFO head; src_*/dst_*
// registered start/stop/end handshakes; level FIFO occupancy; c_done job
// complete; err sticky {underflow, overflow}.
module ss_dp
    import ss_dp_pkg::*;
#(
    parameter int unsigned AW    = DP_AW,
    parameter int unsigned BURST = DP_BURST,
    parameter int unsigned SKID  = DP_SKID
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ss_go,
    input  logic              ss_done,
    input  logic [DATA_W-1:0] rd_dat,
    input  logic              src_xfer,
    input  logic              src_last,
    output logic              src_start,
    output logic              src_stop,
    output logic              src_end,
    input  logic              dst_xfer,
    input  logic              dst_last,
    output logic [DATA_W-1:0] wr_dat,
    output logic              dst_start,
    output logic              dst_stop,
    output logic              dst_end,
    output logic [AW:0]       level,
    output logic              c_done,
    output logic [1:0]        err
);

    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    dp_state_e     state_q, state_d;
    dp_hs_t        hs_q, hs_d;
    logic [1:0]    err_q, err_d;
    logic          c_done_q, c_done_d;

    logic          push_req, pop_req;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [LW-1:0] free;
    logic          drain_tail;
    logic          ovf, unf;

    assign push_req = src_xfer && !src_last;
    assign pop_req  = dst_xfer && !dst_last;

    ss_fifo64 #(
        .AW (AW)
    ) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (push_req),
        .pop      (pop_req),
        .clr      (ss_done),
        .din      (rd_dat),
        .dout     (wr_dat),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A destination end marker before the source finished means the
    // destination chain is shorter than the source chain.
    assign ovf = push_req && fifo_full;
    assign unf = (pop_req && fifo_empty) ||
                 (dst_xfer && dst_last && (state_q == ST_IDLE || state_q == ST_RUN));

    // Next state and sticky error
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (ss_done) begin
            state_d = ST_IDLE;
        end else begin
            if (ovf) err_d[ERR_OVF] = 1'b1;
            if (unf) err_d[ERR_UNF] = 1'b1;
            if (ovf || unf) begin
                state_d = ST_ERR;
            end else begin
                case (state_q)
                    ST_IDLE:  if (ss_go) state_d = ST_RUN;
                    ST_RUN:   if (src_xfer && src_last) state_d = ST_DRAIN;
                    ST_DRAIN: if (fifo_level == '0 && !push_req) state_d = ST_DONE;
                    default:  state_d = state_q;
                endcase
            end
        end
    end

    // Handshakes from the next state and the registered FIFO level, so a
    // push reaches dst_start one cycle after it reaches level.
    always_comb begin
        hs_d       = '0;
        free       = LW'(DEPTH) - fifo_level;
        drain_tail = (state_d == ST_DRAIN) && (fifo_level != '0);
        case (state_d)
            ST_RUN, ST_DRAIN, ST_DONE: begin
                hs_d.src_start = (state_d == ST_RUN) && (free >= LW'(BURST));
                hs_d.src_stop  = (free <= LW'(SKID));
                hs_d.dst_start = (state_d != ST_DONE) &&
                                 ((fifo_level >= LW'(BURST)) || drain_tail);
                hs_d.dst_stop  = (fifo_level <= LW'(SKID)) && !drain_tail;
                hs_d.src_end   = (state_d != ST_RUN);
                hs_d.dst_end   = (state_d == ST_DONE);
            end
            ST_ERR: begin
                // Release both engines from their wait states
                hs_d.src_stop = 1'b1;
                hs_d.dst_stop = 1'b1;
                hs_d.src_end  = 1'b1;
                hs_d.dst_end  = 1'b1;
            end
            default: hs_d = '0;
        endcase
        c_done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            hs_q     <= '0;
            err_q    <= '0;
            c_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hs_q     <= hs_d;
            err_q    <= err_d;
            c_done_q <= c_done_d;
        end
    end

    assign src_start = hs_q.src_start;
    assign src_stop  = hs_q.src_stop;
    assign src_end   = hs_q.src_end;
    assign dst_start = hs_q.dst_start;
    assign dst_stop  = hs_q.dst_stop;
    assign dst_end   = hs_q.dst_end;
    assign level     = fifo_level;
    assign c_done    = c_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ss_dp.sv
// tb_ss_dp: directed bench for ss_dp with a scoreboard on wr_dat.
module tb_ss_dp;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        ss_go;
    logic        ss_done;
    logic [63:0] rd_dat;
    logic        src_xfer;
    logic        src_last;
    logic        src_start;
    logic        src_stop;
    logic        src_end;
    logic        dst_xfer;
    logic        dst_last;
    logic [63:0] wr_dat;
    logic        dst_start;
    logic        dst_stop;
    logic        dst_end;
    logic [4:0]  level;
    logic        c_done;
    logic [1:0]  err;

    int          n_checks;
    int          n_errors;
    logic [63:0] exp_q [$];

    ss_dp dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .ss_go     (ss_go),
        .ss_done   (ss_done),
        .rd_dat    (rd_dat),
        .src_xfer  (src_xfer),
        .src_last  (src_last),
        .src_start (src_start),
        .src_stop  (src_stop),
        .src_end   (src_end),
        .dst_xfer  (dst_xfer),
        .dst_last  (dst_last),
        .wr_dat    (wr_dat),
        .dst_start (dst_start),
        .dst_stop  (dst_stop),
        .dst_end   (dst_end),
        .level     (level),
        .c_done    (c_done),
        .err       (err)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every destination pop must present the oldest expected beat
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && dst_xfer && !dst_last) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_dat: pop with empty scoreboard, got %0h", wr_dat);
            end else begin
                check("wr_dat", wr_dat, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic push_beat(input logic [63:0] d, input bit expect_it);
        src_xfer = 1'b1;
        src_last = 1'b0;
        rd_dat   = d;
        if (expect_it) exp_q.push_back(d);
        tick();
        src_xfer = 1'b0;
    endtask

    task automatic send_last();
        src_xfer = 1'b1;
        src_last = 1'b1;
        tick();
        src_xfer = 1'b0;
        src_last = 1'b0;
    endtask

    task automatic pop_n(input int n);
        dst_xfer = 1'b1;
        repeat (n) tick();
        dst_xfer = 1'b0;
    endtask

    task automatic pulse_go();
        ss_go = 1'b1;
        tick();
        ss_go = 1'b0;
    endtask

    task automatic pulse_done();
        ss_done = 1'b1;
        tick();
        ss_done = 1'b0;
    endtask

    task automatic wait_dst_end(input string name);
        int i;
        for (i = 0; i < 20 && !dst_end; i++) tick();
        check(name, dst_end, 1);
    endtask

    task automatic check_hs(input string name, input logic [5:0] exp);
        check(name, {src_start, src_stop, src_end, dst_start, dst_stop, dst_end}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        wb_rst_i = 1'b1;
        ss_go    = 1'b0;
        ss_done  = 1'b0;
        rd_dat   = '0;
        src_xfer = 1'b0;
        src_last = 1'b0;
        dst_xfer = 1'b0;
        dst_last = 1'b0;
        repeat (3) tick();
        check("reset_level", level, 0);
        check_hs("reset_hs", 6'b000000);
        check("reset_cdone", c_done, 0);
        check("reset_err", err, 0);
        wb_rst_i = 1'b0;
        tick();

        // Basic copy of six beats
        pulse_go();
        check("go_src_start", src_start, 1);
        check("go_dst_start", dst_start, 0);
        for (int i = 1; i <= 6; i++) push_beat(64'(i), 1'b1);
        check("copy_level6", level, 6);
        send_last();
        check("copy_src_end", src_end, 1);
        check("copy_drain_dst_start", dst_start, 1);
        pop_n(6);
        check("copy_level0", level, 0);
        wait_dst_end("copy_dst_end");
        check("copy_cdone_entry", c_done, 0);
        tick();
        check("copy_cdone", c_done, 1);
        dst_xfer = 1'b1;
        dst_last = 1'b1;
        tick();
        dst_xfer = 1'b0;
        dst_last = 1'b0;
        check("done_dst_last_err", err, 0);
        pulse_done();
        check_hs("copy_idle_hs", 6'b000000);
        check("copy_idle_cdone", c_done, 0);

        // Short tail: drain below BURST
        pulse_go();
        push_beat(64'h11, 1'b1);
        push_beat(64'h12, 1'b1);
        send_last();
        check("tail_level", level, 2);
        check("tail_dst_start", dst_start, 1);
        check("tail_dst_stop", dst_stop, 0);
        dst_xfer = 1'b1;
        tick();
        check("tail_dst_stop_l1", dst_stop, 0);
        tick();
        check("tail_dst_stop_l0", dst_stop, 0);
        dst_xfer = 1'b0;
        wait_dst_end("tail_dst_end");
        pulse_done();

        // Backpressure and simultaneous push/pop
        pulse_go();
        for (int i = 0; i < 14; i++) push_beat(64'h100 + 64'(i), 1'b1);
        tick();
        check("bp_level14", level, 14);
        check("bp_src_stop", src_stop, 1);
        check("bp_src_start", src_start, 0);
        check("bp_err", err, 0);
        repeat (2) tick();
        check("bp_level_hold", level, 14);
        pop_n(2);
        tick();
        check("bp_level12", level, 12);
        check("bp_src_start_again", src_start, 1);
        check("bp_src_stop_low", src_stop, 0);
        pop_n(4);
        check("sim_level8", level, 8);
        for (int i = 0; i < 5; i++) begin
            src_xfer = 1'b1;
            rd_dat   = 64'h200 + 64'(i);
            exp_q.push_back(rd_dat);
            dst_xfer = 1'b1;
            tick();
            check("sim_level_hold", level, 8);
        end
        src_xfer = 1'b0;
        dst_xfer = 1'b0;
        send_last();
        pop_n(8);
        wait_dst_end("bp_dst_end");
        check("bp_scoreboard_drained", 64'(exp_q.size()), 0);
        pulse_done();

        // Abort mid-job
        pulse_go();
        for (int i = 0; i < 5; i++) push_beat(64'h50 + 64'(i), 1'b1);
        check("abort_level5", level, 5);
        pulse_done();
        exp_q.delete();
        check("abort_level0", level, 0);
        check_hs("abort_hs", 6'b000000);
        check("abort_cdone", c_done, 0);

        // Overflow: push into a full FIFO
        pulse_go();
        for (int i = 0; i < 16; i++) push_beat(64'h300 + 64'(i), 1'b1);
        check("ovf_level16", level, 16);
        push_beat(64'hdead, 1'b0);
        check("ovf_err", err, 2'b01);
        check_hs("ovf_hs", 6'b011011);
        check("ovf_level_kept", level, 16);
        pulse_done();
        exp_q.delete();
        check("ovf_err_sticky", err, 2'b01);
        check_hs("ovf_idle_hs", 6'b000000);
        check("ovf_idle_level", level, 0);

        // Underflow: destination end marker while source still running
        wb_rst_i = 1'b1;
        tick();
        check("rst_err_clear", err, 0);
        wb_rst_i = 1'b0;
        tick();
        pulse_go();
        dst_xfer = 1'b1;
        dst_last = 1'b1;
        tick();
        dst_xfer = 1'b0;
        dst_last = 1'b0;
        check("unf_err", err, 2'b10);
        check("unf_dst_end", dst_end, 1);
        check("unf_src_start", src_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ss_dp.md
Name: ss_dp

Overview:
- Data-path stage between the source (read, rw=0) and destination (write, rw=1) scatter-gather engines of one ADMA channel.
- Captures 64-bit read beats acknowledged by the source engine into an internal FIFO.
- Presents FIFO head data to the destination write bus.
- Generates the start/stop/end flow-control handshakes for both engines and reports job completion back to ss_adma.

Parameters:
- AW, 4, log2 of FIFO depth in 64-bit entries (default 16 entries).
- BURST, 4, minimum entries of free space (source) or data (destination) needed to start a burst.
- SKID, 2, free-entry and data-entry margin at which stop is raised; covers the registered stop and one in-flight ack.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- ss_go  in  1  one-cycle pulse from ss_adma: job programmed, begin data movement
- ss_done  in  1  ss_adma abort/clear; synchronous flush to IDLE
- rd_dat  in  64  source WB read data {wbs_dat64_o, wbs_dat_o}
- src_xfer  in  1  source beat accepted; with src_last=0 it carries rd_dat
- src_last  in  1  qualifies src_xfer as the end-of-chain marker; carries no data
- src_start  out  1  source may issue a burst
- src_stop  out  1  source must terminate its burst
- src_end  out  1  source job finished
- dst_xfer  in  1  destination beat accepted; pops FIFO head
- dst_last  in  1  qualifies dst_xfer as the destination end-of-chain marker; no pop
- wr_dat  out  64  FIFO head data to the destination write bus
- dst_start  out  1  destination may issue a burst
- dst_stop  out  1  destination must terminate its burst
- dst_end  out  1  destination job finished
- level  out  AW+1  FIFO occupancy
- c_done  out  1  job complete, registered
- err  out  2  sticky: [0] overflow, [1] underflow

Behaviour:
- Reset: wb_rst_i asynchronous, active-high; clock wb_clk_i. Reset clears all outputs to 0, level to 0, FIFO pointers to 0 and state to IDLE.
- ss_done has priority over every other input. Takes effect next edge: state to IDLE, pointers cleared, err kept (sticky until reset).
- FIFO: depth 2^AW x 64. Pointers are AW+1 bits wide; full when MSBs differ and the rest are equal.
  - Push on src_xfer & ~src_last.
  - Pop on dst_xfer & ~dst_last.
  - Simultaneous push and pop leave level unchanged.
  - wr_dat is the combinational head; it is valid only while level > 0.
- Push when full: data dropped, err[0] set, state to ERR.
- Pop when empty: err[1] set, state to ERR.
- All start/stop/end outputs are registered from next-state level and state.
  - src_start = RUN & (free >= BURST).
  - src_stop = (free <= SKID).
  - dst_start = (RUN|DRAIN) & (level >= BURST | (DRAIN & level > 0)).
  - dst_stop = (level <= SKID) & ~(DRAIN & level > 0).
- States:
  - IDLE: all handshakes 0. On ss_go go to RUN.
  - RUN: normal flow. src_xfer & src_last latches src_seen, drives src_end=1 held until IDLE, then go to DRAIN.
  - DRAIN: source finished, destination empties the FIFO. When level == 0 and no push is pending: dst_end=1 held, go to DONE.
  - DONE: c_done=1 the cycle after entry and held; dst_last is accepted here without error. Leave only on ss_done, to IDLE.
  - ERR: all start outputs 0, both stop outputs 1, both end outputs 1 so both engines leave their wait states. Leave only on ss_done or reset.
- dst_last before DRAIN is an underflow (err[1], ERR): the destination chain is shorter than the source.
- Latency:
  - Push to level update: 1 cycle.
  - Push to dst_start visibility: 2 cycles.
  - Pop: the head advances the same edge.

Decomposition:
- Shared package/include ss_defs: dp state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3, ERR=4), err bit indices, default AW/BURST/SKID.
- One sub-module, ss_fifo64: synchronous 2^AW x 64 FIFO.
  - Inputs: push, pop, din, clr.
  - Outputs: dout, level, full, empty.
  - Inferred RAM with registered write and asynchronous read.
- ss_dp holds the control FSM and handshake logic.

Test Plan:
- Basic copy:
  - Stimulus: ss_go, then 6 src beats 0x1..0x6, src_last; destination pops each as dst_start allows.
  - Required: wr_dat sequence 0x1..0x6; src_end one cycle after src_last; dst_end when level=0; c_done next cycle.
- Backpressure:
  - Stimulus: AW=4, destination idle, 14 src beats.
  - Required: src_stop rises when level reaches 14 (free=2); no err; level stays 14 until pops begin, then src_start reasserts at free>=4.
- Short tail:
  - Stimulus: 2 beats then src_last.
  - Required: DRAIN asserts dst_start with level=2 (below BURST); dst_stop stays 0 until empty.
- Simultaneous push and pop at level=8 for 5 cycles -> level stays 8, data order preserved.
- Overflow:
  - Stimulus: force a push at level=16.
  - Required: err=2'b01, both stops=1, both ends=1; ss_done then returns to IDLE with err still 01.
- Abort mid-job: ss_done during RUN with level=5 -> next edge level=0, all handshakes 0, c_done=0.
